cost_display_seq: RTL and testbench

Sequential, parametrised cost-to-seven-segment display driver for the fuel-pump front panel. It accepts a binary cost value on a start strobe and converts it to BCD with an iterative shift-and-add-3 engine, one bit per clock. It then registers one seven-segment code per digit, with overflow indication and optional leading-zero blanking. It sits between the pricing/accumulation logic and the board's seven-segment pins. It replaces the purely combinational per-digit divide/modulo decoding used up to now.

---
 rtl/cost_disp_pkg.sv | 31 +++
 rtl/cost_display_seq_seg7_enc.sv | 20 ++
 rtl/cost_display_seq.sv | 172 +++++++++++++++++
 tb/tb_cost_display_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cost_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cost_disp_pkg
// Purpose  : Shared FSM state type and seven-segment constants for the
//            cost display driver (active-low, bit0=a .. bit6=g).
// Revision : 1.0 - initial release
// ============================================================================
package cost_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index n holds the code for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  // Decimal digits needed for 2^w-1: floor(w*log10(2)) + 1.
  function automatic int bcd_nibbles(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cost_display_seq_seg7_enc.sv
`default_nettype none
// ============================================================================
// Module   : seg7_enc
// Purpose  : Combinational 4-bit digit to active-low seven-segment code.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_enc
  import cost_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (digit_i <= 4'd9) seg_o = SEG_DIGITS[digit_i];
  end

endmodule
`default_nettype wire

// File: rtl/cost_display_seq.sv
`default_nettype none
// ============================================================================
// Module   : cost_display_seq
// Purpose  : Iterative binary-to-BCD (shift-and-add-3) seven-segment driver.
//            Define COST_DISP_BLANK_EN to enable leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module cost_display_seq
  import cost_disp_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      cost,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int NIB_MIN = bcd_nibbles(WIDTH);
  // One spare nibble above DIGITS always exists so the overflow slice is never empty.
  localparam int NIBS    = ((NIB_MIN > DIGITS) ? NIB_MIN : DIGITS) + 1;
  localparam int CNT_W   = $clog2(WIDTH + 1);
  localparam int CAT_W   = 4 * NIBS + WIDTH;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

`ifdef COST_DISP_BLANK_EN
  localparam logic [6:0] SEG_RST_UPPER = SEG_BLANK;
`else
  localparam logic [6:0] SEG_RST_UPPER = SEG_DIGITS[0];
`endif

  function automatic logic [7*DIGITS-1:0] seg_reset();
    logic [7*DIGITS-1:0] s;
    for (int i = 0; i < DIGITS; i++)
      s[7*i +: 7] = (i == 0) ? SEG_DIGITS[0] : SEG_RST_UPPER;
    return s;
  endfunction

  localparam logic [7*DIGITS-1:0] SEG_RST = seg_reset();

  state_e state_q, state_d;
  logic   accept, shift_en, load_en;

  logic [WIDTH-1:0]    sr_q, sr_d;
  logic [4*NIBS-1:0]   scr_q, scr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*NIBS-1:0]   w_adj;
  logic [CAT_W-1:0]    w_cat;
  logic                w_ovf;
  logic [DIGITS-1:0]   w_lit;
  logic [7*DIGITS-1:0] w_enc, w_seg;

  logic                busy_q, done_q, ovf_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [7*DIGITS-1:0] seg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state_q == IDLE) && start;
    shift_en = (state_q == SHIFT);
    load_en  = (state_q == LOAD);
  end

  always_comb begin
    w_adj = '0;
    for (int n = 0; n < NIBS; n++)
      w_adj[4*n +: 4] = (scr_q[4*n +: 4] >= 4'd5) ? scr_q[4*n +: 4] + 4'd3
                                                   : scr_q[4*n +: 4];
    w_cat = {w_adj, sr_q} << 1;
  end

  always_comb begin
    sr_d  = sr_q;
    scr_d = scr_q;
    cnt_d = cnt_q;
    if (accept) begin
      sr_d  = cost;
      scr_d = '0;
      cnt_d = CNT_LOAD;
    end else if (shift_en) begin
      {scr_d, sr_d} = w_cat;
      cnt_d         = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      scr_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
    end
  end

  assign w_ovf = |scr_q[4*NIBS-1:4*DIGITS];

`ifdef COST_DISP_BLANK_EN
  // A digit is lit when it or any higher displayed digit is non-zero.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    w_lit = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen     = seen | (|scr_q[4*i +: 4]);
      w_lit[i] = seen | (i == 0);
    end
  end
`else
  assign w_lit = '1;
`endif

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
      seg7_enc u_enc (
        .digit_i (scr_q[4*g +: 4]),
        .seg_o   (w_enc[7*g +: 7])
      );
      assign w_seg[7*g +: 7] = w_ovf      ? SEG_DASH :
                               w_lit[g]   ? w_enc[7*g +: 7] : SEG_BLANK;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      bcd_q  <= '0;
      seg_q  <= SEG_RST;
    end else begin
      // busy covers the done cycle as well, dropping one edge after LOAD.
      busy_q <= accept || (state_q != IDLE);
      done_q <= load_en;
      if (load_en) begin
        ovf_q <= w_ovf;
        bcd_q <= scr_q[4*DIGITS-1:0];
        seg_q <= w_seg;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;
  assign seg  = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_cost_display_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cost_display_seq
// Purpose  : Directed self-checking bench for cost_display_seq (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cost_display_seq;

  localparam int WIDTH  = 24;
  localparam int DIGITS = 7;

`ifdef COST_DISP_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [WIDTH-1:0]      cost = '0;
  logic                  busy, done, ovf;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;

  int checks = 0;
  int errors = 0;

  cost_display_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .cost  (cost),
    .start (start),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .bcd   (bcd),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_seg(input logic [4*DIGITS-1:0] b, input bit ov);
    logic [7*DIGITS-1:0] s;
    int top;
    top = 0;
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] != 4'd0) top = i;
    for (int i = 0; i < DIGITS; i++)
      s[7*i +: 7] = ov ? 7'h3F : ((BLANK && i > top) ? 7'h7F : enc(b[4*i +: 4]));
    return s;
  endfunction

  function automatic logic [7*DIGITS-1:0] seg_rst_exp();
    logic [7*DIGITS-1:0] s;
    for (int i = 0; i < DIGITS; i++) s[7*i +: 7] = (i == 0 || !BLANK) ? 7'h40 : 7'h7F;
    return s;
  endfunction

  task automatic launch(input logic [WIDTH-1:0] c);
    @(negedge clk);
    cost  = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic convert(input string tag, input logic [WIDTH-1:0] c,
                         input logic [4*DIGITS-1:0] eb, input bit eo);
    int n;
    launch(c);
    check({tag, " busy_start"}, busy, 1);
    wait_done(n);
    check({tag, " latency"}, n, 25);
    check({tag, " bcd"}, bcd, eb);
    check({tag, " ovf"}, ovf, eo);
    check({tag, " seg"}, seg, exp_seg(eb, eo));
    check({tag, " busy_done"}, busy, 1);
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, done, 0);
    check({tag, " busy_fall"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n1, n2, dcount, first;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst ovf", ovf, 0);
    check("rst bcd", bcd, 0);
    check("rst seg", seg, seg_rst_exp());
    @(negedge clk);
    rst = 1'b0;

    convert("c1234567", 24'd1234567, 28'h1234567, 1'b0);
    check("c1234567 dig6", seg[48:42], 7'h79);
    check("c1234567 dig0", seg[6:0], 7'h78);

    convert("c305", 24'd305, 28'h0000305, 1'b0);
    check("c305 low", seg[20:0], {7'h30, 7'h40, 7'h12});
    check("c305 high", seg[48:21], BLANK ? {4{7'h7F}} : {4{7'h40}});

    convert("c9999999", 24'd9999999, 28'h9999999, 1'b0);
    convert("c10000000", 24'd10000000, 28'h0000000, 1'b1);
    check("c10000000 dash", seg, {7{7'h3F}});

    convert("c0", 24'd0, 28'h0000000, 1'b0);
    convert("cmax", 24'd16777215, 28'h6777215, 1'b1);

    // Start during busy is ignored
    launch(24'd111);
    dcount = 0;
    first  = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) begin
        start = 1'b1;
        cost  = 24'd222;
      end
      if (i == 10) start = 1'b0;
      if (done) begin
        dcount++;
        if (first < 0) first = i;
      end
    end
    check("ign dones", dcount, 1);
    check("ign latency", first, 25);
    check("ign bcd", bcd, 28'h0000111);
    convert("c222", 24'd222, 28'h0000222, 1'b0);

    // start held high re-triggers right after LOAD
    @(negedge clk);
    cost  = 24'd4321;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(n1);
    wait_done(n2);
    start = 1'b0;
    check("b2b first", n1, 25);
    check("b2b spacing", n2, 26);
    check("b2b bcd", bcd, 28'h0004321);
    repeat (30) @(posedge clk);

    // Reset mid-conversion
    launch(24'd7654321);
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mrst busy", busy, 0);
    check("mrst done", done, 0);
    check("mrst bcd", bcd, 0);
    check("mrst ovf", ovf, 0);
    check("mrst seg", seg, seg_rst_exp());
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("mrst no_done", dcount, 0);
    check("mrst bcd_hold", bcd, 0);
    convert("c42", 24'd42, 28'h0000042, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
